wb_sequencer: RTL
=================

# wb_sequencer

Register-file write-back sequencer for the multicycle CPU. It arbitrates among eight write-back requesters, one per data input of the register-write data-source mux. For the granted requester it drives that mux's 4-bit selector, the destination register number and the register-file write enable. After reset it also performs a one-time write of the stack-pointer constant (mux code 4'b1000, value 227) into the stack-pointer register.

## Interface
Parameters:
- SP_INDEX, 29: destination register for the post-reset stack-pointer write.
- SP_SEL, 4'b1000: mux selector code that routes the constant 227.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- wb_enable  input  1  when 0, no new grant is issued; a write already in progress still completes.
- req  input  8  req[i] = requester i (mux data_i) wants a write; level held until its ack.
- dest_bus  input  40  destination registers; dest_bus[5i+4:5i] belongs to requester i.
- ack  output  8  one-hot, one-cycle pulse; ack[i] = requester i's write is happening this cycle.
- datasrc_sel  output  4  selector to the register-write data-source mux.
- reg_dst  output  5  register-file write address.
- reg_write  output  1  register-file write enable.
- init_done  output  1  0 until the stack-pointer write has completed, then 1 until the next reset.

## Operation
- States: INIT, IDLE, WRITE.
- While reset = 0: state = INIT, and every output = 0 (ack, datasrc_sel, reg_dst, reg_write, init_done). This takes effect immediately, asynchronously.
- INIT:
  - On the first rising edge after reset releases, go to WRITE.
  - Outputs for that WRITE: datasrc_sel = SP_SEL, reg_dst = SP_INDEX, reg_write = 1, ack = 0.
  - req and wb_enable are ignored while in INIT.
- IDLE:
  - If wb_enable = 1 and req ≠ 0, choose winner w per the arbitration policy (see Configuration) and go to WRITE.
  - Outputs for that WRITE: datasrc_sel = w (zero-extended to 4 bits), reg_dst = dest_bus[5w+4:5w], ack = one-hot(w).
  - reg_write = 1, except reg_write = 0 when the destination is register 0. The ack is still issued in that case, because a write to $zero is discarded.
  - Otherwise stay in IDLE with ack = 0 and reg_write = 0. datasrc_sel and reg_dst hold their last values.
- WRITE:
  - Always returns to IDLE on the next edge; ack and reg_write drop to 0.
  - If this was the stack-pointer write, init_done goes to 1 on that edge.
- Requester obligations:
  - Hold req[i] and its dest slice stable until ack[i] is seen.
  - Deassert req[i] on the edge that ends ack[i]. req[i] still high in the ack cycle is not counted, because the block is in WRITE then.
- No back-to-back grants: at most one write every 2 cycles.
- req may change while in WRITE without effect; it is sampled only in IDLE.

## Timing
- All outputs are registered; no combinational path from req to any output.
- Grant latency: req[i] high in an IDLE cycle → ack[i], reg_write and datasrc_sel valid in the next cycle, for exactly 1 cycle.
- Stack-pointer write: occurs in cycle 2 after reset release (INIT in cycle 1, WRITE in cycle 2). init_done = 1 from cycle 3.
- Earliest requester ack after reset: cycle 4.
- wb_enable falling during WRITE: the write completes. wb_enable is next sampled in IDLE.
- Simultaneous requests: exactly one is granted per IDLE cycle; the others wait.
- Reset asserted during WRITE: the write is aborted immediately (reg_write = 0, ack = 0). The sequence restarts from INIT, and the stack-pointer write is repeated.

## Configuration
- WB_RR_ARB_EN defined: round-robin arbitration.
  - A 3-bit pointer `last` (reset 3'd7) records the last granted index.
  - Search starts at last+1 and wraps modulo 8; the first set req bit wins.
  - `last` updates only on a requester grant, not on the stack-pointer write.
- WB_RR_ARB_EN undefined: fixed priority, lowest index wins; no pointer register.

## Test plan
- Reset release with req = 0: cycle 2 shows datasrc_sel = 4'b1000, reg_dst = 29, reg_write = 1. init_done = 1 from cycle 3. ack stays 0 throughout.
- req = 8'b0000_0100 with dest 5'd8 after init: next cycle datasrc_sel = 4'd2, reg_dst = 8, reg_write = 1, ack = 8'b0000_0100, all for 1 cycle.
- req = 8'b1000_0001 held, each bit dropped after its ack:
  - Fixed priority: grants 0 then 7.
  - WB_RR_ARB_EN with both held continuously: grants alternate 0, 7, 0, 7.
- req[3] with dest 5'd0: ack[3] pulses, reg_write stays 0.
- wb_enable = 0 with req = 8'hFF for 5 cycles: no ack, reg_write = 0. Raise wb_enable: grant occurs 1 cycle later.
- reset pulsed low in the WRITE cycle of a requester grant: reg_write and ack drop immediately. After release, the stack-pointer write repeats before any requester ack.

Source files
------------

// File: rtl/wb_sequencer.sv
// wb_sequencer: register-file write-back sequencer with a one-time post-reset stack-pointer write.
// Define WB_RR_ARB_EN for round-robin arbitration; the default build uses fixed priority (lowest index).
module wb_sequencer #(
  parameter logic [4:0] SP_INDEX = 5'd29,
  parameter logic [3:0] SP_SEL   = 4'b1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_enable,
  input  logic [7:0]  req,
  input  logic [39:0] dest_bus,
  output logic [7:0]  ack,
  output logic [3:0]  datasrc_sel,
  output logic [4:0]  reg_dst,
  output logic        reg_write,
  output logic        init_done
);
  typedef enum logic [1:0] {INIT, IDLE, WRITE} state_t;
  state_t      state;
  logic        sp_wr;
  logic [2:0]  win, lo;
  logic [7:0]  cand;
  logic [4:0]  dest [8];
`ifdef WB_RR_ARB_EN
  logic [2:0]  last, start;
  logic [15:0] dbl;
  // rotate req so the search always begins at bit 0, then undo the rotation
  always_comb begin
    start = last + 3'd1;
    dbl = {req, req} >> start;
    cand = dbl[7:0];
  end
  assign win = lo + start;
`else
  assign cand = req;
  assign win = lo;
`endif
  always_comb begin
    lo = 3'd0;
    for (int i = 7; i >= 0; i--) if (cand[i]) lo = 3'(i);
  end
  always_comb for (int i = 0; i < 8; i++) dest[i] = dest_bus[5*i +: 5];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= INIT;
      ack <= '0;
      datasrc_sel <= '0;
      reg_dst <= '0;
      reg_write <= 1'b0;
      init_done <= 1'b0;
      sp_wr <= 1'b0;
`ifdef WB_RR_ARB_EN
      last <= 3'd7;
`endif
    end else
      case (state)
        INIT: begin
          state <= WRITE;
          datasrc_sel <= SP_SEL;
          reg_dst <= SP_INDEX;
          reg_write <= 1'b1;
          ack <= '0;
          sp_wr <= 1'b1;
        end
        IDLE:
          if (wb_enable && |req) begin
            state <= WRITE;
            datasrc_sel <= {1'b0, win};
            reg_dst <= dest[win];
            // writes to $zero still ack but never strobe the register file
            reg_write <= |dest[win];
            ack <= 8'd1 << win;
            sp_wr <= 1'b0;
`ifdef WB_RR_ARB_EN
            last <= win;
`endif
          end else begin
            ack <= '0;
            reg_write <= 1'b0;
          end
        default: begin
          state <= IDLE;
          ack <= '0;
          reg_write <= 1'b0;
          sp_wr <= 1'b0;
          if (sp_wr) init_done <= 1'b1;
        end
      endcase
endmodule
